// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional misalignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sext;
  } req_t;

  // Size 2'b11 is a word access, so anything that is not byte/half checks word alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == SZ_HALF) bad = addr_lo[0];
    else if (size != SZ_BYTE) bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store mask/data shift and load shift/extension.
// Bits shifted beyond the 32-bit word (or past lane 3) are simply dropped.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [3:0]  w_base_mask;
  logic [4:0]  w_shamt;
  logic [31:0] w_raw;

  // NOTE: every combinational output gets a value on every path (default arm), so no latch is inferred.
  always_comb begin
    unique case (i_size)
      SZ_BYTE: w_base_mask = 4'b0001;
      SZ_HALF: w_base_mask = 4'b0011;
      default: w_base_mask = 4'b1111;
    endcase
  end

  assign w_shamt = {i_addr_lo, 3'b000};
  assign o_wmask = w_base_mask << i_addr_lo;
  assign o_wdata = i_wdata << w_shamt;
  assign w_raw   = i_rword >> w_shamt;

  always_comb begin
    unique case (i_size)
      SZ_BYTE: o_rdata = i_sext ? {{24{w_raw[7]}}, w_raw[7:0]}   : {24'h0, w_raw[7:0]};
      SZ_HALF: o_rdata = i_sext ? {{16{w_raw[15]}}, w_raw[15:0]} : {16'h0, w_raw[15:0]};
      default: o_rdata = w_raw;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one load/store at a time over valid/ready.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses as errors.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          r_state;
  state_t          w_next;
  req_t            r_req;
  logic [CW-1:0]   r_cnt;
  logic            r_req_ready;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_commit;
  logic            w_resp_valid;
  logic [29:0]     w_word;
  logic [AW-1:0]   w_idx;
  logic            w_below;
  logic            w_above;
  logic            w_misalign;
  logic            w_err;
  logic [3:0]      w_wmask;
  logic [31:0]     w_wdata_sh;
  logic [31:0]     w_rword;
  logic [31:0]     w_load;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (req_valid && r_req_ready) w_next = ST_WAIT;
      ST_WAIT: if (r_cnt == '0)              w_next = ST_RESP;
      ST_RESP: if (resp_ready)               w_next = ST_IDLE;
      default:                               w_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_resp_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: w_accept     = req_valid && r_req_ready;
      ST_WAIT: w_commit     = (r_cnt == '0);
      ST_RESP: w_resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Ready is registered so it is low out of reset and only rises on the first clock after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_req_ready <= 1'b0;
    else        r_req_ready <= (w_next == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_req <= '{store: req_store, addr: req_addr, wdata: req_wdata,
                 size: req_size, sext: req_sext};
      r_cnt <= CW'(LATENCY - 1);
    end else if (r_state == ST_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // ---------------- address decode and error ----------------
  // BASE_ADDR is word aligned, so the word index is a subtraction on bits [31:2].
  assign w_word  = r_req.addr[31:2] - BASE_ADDR[31:2];
  assign w_idx   = w_word[AW-1:0];
  assign w_below = (r_req.addr < BASE_ADDR);
  assign w_above = ({2'b00, w_word} >= 32'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = is_misaligned(r_req.size, r_req.addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_below || w_above || w_misalign;

  dmem_lane_align u_align (
    .i_addr_lo (r_req.addr[1:0]),
    .i_size    (r_req.size),
    .i_sext    (r_req.sext),
    .i_wdata   (r_req.wdata),
    .i_rword   (w_rword),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata_sh),
    .o_rdata   (w_load)
  );

  // ---------------- storage ----------------
  assign w_rword = r_mem[w_idx];

  // NOTE: the array is deliberately not reset; its contents survive rst_n and start undefined.
  always_ff @(posedge clk) begin
    if (w_commit && r_req.store && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  // ---------------- response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_err;
      r_rdata <= (r_req.store || w_err) ? 32'h0 : w_load;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = w_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=4.
// Expected responses are queued at request acceptance and compared at response time.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_store  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [1:0]  req_size   [2];
  logic        req_sext   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h8000_0000),
      .LATENCY     ((g == 0) ? 2 : 4)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_store  (req_store[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_size   (req_size[g]),
      .req_sext   (req_sext[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic err, input string name);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    e.name  = name;
    sb_q.push_back(e);
  endtask

  task automatic drive_req(input int d, input logic st, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic sext);
    req_store[d] = st;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_size[d]  = size;
    req_sext[d]  = sext;
    req_valid[d] = 1'b1;
  endtask

  // Present a request, wait for it to be accepted and queue its expected response.
  task automatic send(input int d, input logic st, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [1:0] size, input logic sext,
                      input logic [31:0] exp_rdata, input logic exp_err, input string name);
    int n = 0;
    drive_req(d, st, addr, wdata, size, sext);
    while (req_ready[d] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (req_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_wait: req_ready=%b after %0d cycles, required 1", name, req_ready[d], n);
    end
    step();
    req_valid[d] = 1'b0;
    push_exp(exp_rdata, exp_err, name);
    checks++;
    if (req_ready[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b after accept, required 0", name, req_ready[d]);
    end
  endtask

  // Wait for a response, compare against the scoreboard, optionally stall, then handshake.
  task automatic recv(input int d, input int hold);
    int   k = 0;
    exp_t e;
    while (resp_valid[d] !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: response on dut %0d with nothing expected", d);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (k != lat_of(d)) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", e.name, k, lat_of(d));
    end
    checks++;
    if (resp_rdata[d] !== e.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h, required %h", e.name, resp_rdata[d], e.rdata);
    end
    checks++;
    if (resp_err[d] !== e.err) begin
      errors++;
      $display("FAIL %s err: got %b, required %b", e.name, resp_err[d], e.err);
    end
    checks++;
    if (req_ready[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_during_resp: req_ready=%b, required 0", e.name, req_ready[d]);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== e.rdata ||
          resp_err[d] !== e.err || req_ready[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                 e.name, i, resp_valid[d], resp_rdata[d], resp_err[d], req_ready[d],
                 e.rdata, e.err);
      end
    end
    resp_ready[d] = 1'b1;
    step();
    resp_ready[d] = 1'b0;
    checks++;
    if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s post_handshake: req_ready=%b resp_valid=%b, required 1 0",
               e.name, req_ready[d], resp_valid[d]);
    end
  endtask

  task automatic check_reset_outputs(input int d, input string name);
    checks++;
    if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 ||
        resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b rdata=%h err=%b, required 0 0 00000000 0",
               name, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_store[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_size[d] = SZ_WORD; req_sext[d] = 1'b0; resp_ready[d] = 1'b0;
    end
    repeat (3) step();
    check_reset_outputs(0, "reset_dut0");
    check_reset_outputs(1, "reset_dut1");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    #1;
    check_reset_outputs(0, "reset_release");
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL ready_rise dut%0d: got %b, required 1", d, req_ready[d]);
      end
    end
  endtask

  task automatic test_word();
    send(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, SZ_WORD, 0, 32'h0, 0, "sw_10");
    recv(0, 0);
    send(0, 0, 32'h8000_0010, 32'h0, SZ_WORD, 0, 32'hDEAD_BEEF, 0, "lw_10");
    recv(0, 0);
  endtask

  task automatic test_byte();
    send(0, 1, 32'h8000_0011, 32'h0000_00A5, SZ_BYTE, 0, 32'h0, 0, "sb_11");
    recv(0, 0);
    send(0, 0, 32'h8000_0010, 32'h0, SZ_WORD, 0, 32'hDEAD_A5EF, 0, "lw_after_sb");
    recv(0, 0);
    send(0, 0, 32'h8000_0011, 32'h0, SZ_BYTE, 1, 32'hFFFF_FFA5, 0, "lb_11");
    recv(0, 0);
    send(0, 0, 32'h8000_0011, 32'h0, SZ_BYTE, 0, 32'h0000_00A5, 0, "lbu_11");
    recv(0, 0);
  endtask

  task automatic test_half();
    send(0, 0, 32'h8000_0012, 32'h0, SZ_HALF, 1, 32'hFFFF_DEAD, 0, "lh_12");
    recv(0, 0);
    send(0, 0, 32'h8000_0012, 32'h0, SZ_HALF, 0, 32'h0000_DEAD, 0, "lhu_12");
    recv(0, 0);
    // Half store at lane 3: the upper byte falls off the word (or errors when checked).
    send(0, 1, 32'h8000_0018, 32'h1122_3344, SZ_WORD, 0, 32'h0, 0, "sw_18");
    recv(0, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    send(0, 1, 32'h8000_001B, 32'h0000_BEEF, SZ_HALF, 0, 32'h0, 1, "sh_1b");
    recv(0, 0);
    send(0, 0, 32'h8000_0018, 32'h0, SZ_WORD, 0, 32'h1122_3344, 0, "lw_18");
`else
    send(0, 1, 32'h8000_001B, 32'h0000_BEEF, SZ_HALF, 0, 32'h0, 0, "sh_1b");
    recv(0, 0);
    send(0, 0, 32'h8000_0018, 32'h0, SZ_WORD, 0, 32'hEF22_3344, 0, "lw_18");
`endif
    recv(0, 0);
  endtask

  task automatic test_back_pressure();
    send(0, 0, 32'h8000_0010, 32'h0, SZ_WORD, 0, 32'hDEAD_A5EF, 0, "bp_lw");
    drive_req(0, 0, 32'h8000_0011, 32'h0, SZ_BYTE, 0);
    recv(0, 5);
    step();
    req_valid[0] = 1'b0;
    push_exp(32'h0000_00A5, 1'b0, "bp_second");
    checks++;
    if (req_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_accept: req_ready=%b, required 0", req_ready[0]);
    end
    recv(0, 0);
  endtask

  task automatic test_range();
    send(0, 1, 32'h8000_0FFC, 32'h0, SZ_WORD, 0, 32'h0, 0, "sw_last");
    recv(0, 0);
    send(0, 1, 32'h7FFF_FFFC, 32'h1, SZ_WORD, 0, 32'h0, 1, "sw_below");
    recv(0, 0);
    send(0, 0, 32'h8000_0FFC, 32'h0, SZ_WORD, 0, 32'h0, 0, "lw_last");
    recv(0, 0);
    send(0, 0, 32'h8000_1000, 32'h0, SZ_WORD, 0, 32'h0, 1, "lw_above");
    recv(0, 0);
    send(0, 0, 32'h8000_0010, 32'h0, SZ_WORD, 0, 32'hDEAD_A5EF, 0, "lw_unchanged");
    recv(0, 0);
`ifdef DMEM_MISALIGN_CHECK_EN
    send(0, 0, 32'h8000_0011, 32'h0, SZ_WORD, 0, 32'h0, 1, "lw_misaligned");
`else
    send(0, 0, 32'h8000_0011, 32'h0, SZ_WORD, 0, 32'h00DE_ADA5, 0, "lw_misaligned");
`endif
    recv(0, 0);
  endtask

  task automatic test_reset_in_wait();
    send(1, 1, 32'h8000_0024, 32'hCAFE_F00D, SZ_WORD, 0, 32'h0, 0, "l4_sw_24");
    recv(1, 0);
    send(1, 0, 32'h8000_0024, 32'h0, SZ_WORD, 0, 32'hCAFE_F00D, 0, "l4_lw_24");
    recv(1, 0);
    send(1, 1, 32'h8000_0020, 32'h1234_5678, SZ_WORD, 0, 32'h0, 0, "l4_sw_abort");
    void'(sb_q.pop_back());
    step();
    step();
    rst_n[1] = 1'b0;
    #1;
    check_reset_outputs(1, "reset_in_wait");
    step();
    step();
    rst_n[1] = 1'b1;
    step();
    send(1, 1, 32'h8000_0020, 32'h0, SZ_WORD, 0, 32'h0, 0, "l4_sw_20");
    recv(1, 0);
    send(1, 1, 32'h8000_0020, 32'h0000_0078, SZ_BYTE, 0, 32'h0, 0, "l4_sb_20");
    recv(1, 0);
    send(1, 0, 32'h8000_0020, 32'h0, SZ_WORD, 0, 32'h0000_0078, 0, "l4_lw_20");
    recv(1, 0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_back_pressure();
    test_range();
    test_reset_in_wait();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
